// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the two buses owned by the fetch unit:
//   - instruction-memory request bus (imem_rd/imem_addr out, imem_data/
//     imem_done/imem_err back)
//   - IF/ID pipeline-register write bus (ifid_en, instr_out, pc_current_out,
//     pc_plus_two_out, err_out)
// Modports:
//   master : the fetch unit (drives requests and the IF/ID write bus)
//   slave  : memory / IF/ID side (drives memory responses)
// ----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        imem_err;
    logic        ifid_en;
    logic [15:0] instr_out;
    logic [15:0] pc_current_out;
    logic [15:0] pc_plus_two_out;
    logic        err_out;

    modport master (
        output imem_rd, imem_addr, ifid_en, instr_out, pc_current_out,
               pc_plus_two_out, err_out,
        input  imem_data, imem_done, imem_err
    );

    modport slave (
        input  imem_rd, imem_addr, ifid_en, instr_out, pc_current_out,
               pc_plus_two_out, err_out,
        output imem_data, imem_done, imem_err
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Writer side of the IF/ID pipeline register. Owns the PC, runs the
// instruction-memory request handshake and presents instr/pc/pc+2/err to
// IF/ID together with a write enable. Handles decode stall, redirects from
// later stages, HALT (opcode 5'b00000) and memory errors.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   stall_in        IF/ID must hold this cycle
//   redirect_valid  redirect request, redirect_pc is the new PC
//   bus (master)    imem request/response and IF/ID write bus
// Optional feature:
//   FETCH_ALIGN_CHECK_EN  when defined, an odd PC in FETCH issues no request
//                         and delivers err_out=1 / NOP, then halts.
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall_in,
    input  logic         redirect_valid,
    input  logic [15:0]  redirect_pc,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SQUASH = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t      state_r, state_nxt_s, state_base_s;
    logic [15:0] pc_r, pc_nxt_s, pc_base_s;
    logic [15:0] sq_addr_r, sq_addr_nxt_s;
    logic [15:0] buf_instr_r, buf_instr_nxt_s;
    logic        buf_err_r, buf_err_nxt_s;
    logic        buf_halt_r, buf_halt_nxt_s;

    logic        req_s;
    logic [15:0] addr_s;
    logic        have_s;
    logic [15:0] del_instr_s;
    logic        del_err_s;
    logic        del_halt_s;
    logic        en_base_s;
    logic        ifid_en_s;
    logic [15:0] instr_s;
    logic        err_s;
    logic        misalign_s;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_s = pc_r[0];
`else
    assign misalign_s = 1'b0;
`endif

    // Next-state, request and IF/ID write decode; redirect overrides the base decision.
    always_comb begin
        state_base_s    = state_r;
        pc_base_s       = pc_r;
        en_base_s       = 1'b0;
        buf_instr_nxt_s = buf_instr_r;
        buf_err_nxt_s   = buf_err_r;
        buf_halt_nxt_s  = buf_halt_r;
        req_s           = 1'b0;
        addr_s          = pc_r;
        have_s          = 1'b0;
        del_instr_s     = NOP_INSTR;
        del_err_s       = 1'b0;
        del_halt_s      = 1'b0;
        instr_s         = NOP_INSTR;
        err_s           = 1'b0;

        case (state_r)
            ST_FETCH, ST_WAIT: begin
                if ((state_r == ST_FETCH) && misalign_s) begin
                    // Misaligned PC: no memory access, fault is delivered directly.
                    have_s     = 1'b1;
                    del_err_s  = 1'b1;
                    del_halt_s = 1'b1;
                end else begin
                    req_s = 1'b1;
                    if (bus.imem_done) begin
                        have_s      = 1'b1;
                        del_err_s   = bus.imem_err;
                        del_instr_s = bus.imem_err ? NOP_INSTR : bus.imem_data;
                        del_halt_s  = bus.imem_err | (bus.imem_data[15:11] == 5'b00000);
                    end else begin
                        have_s = 1'b0;
                    end
                end
                instr_s = del_instr_s;
                err_s   = del_err_s;
                if (have_s && !stall_in) begin
                    en_base_s    = 1'b1;
                    pc_base_s    = pc_r + 16'd2;
                    state_base_s = del_halt_s ? ST_HALTED : ST_FETCH;
                end else if (have_s) begin
                    // Decode is stalled: park the fetched word until it can be written.
                    buf_instr_nxt_s = del_instr_s;
                    buf_err_nxt_s   = del_err_s;
                    buf_halt_nxt_s  = del_halt_s;
                    state_base_s    = ST_HOLD;
                end else begin
                    state_base_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                instr_s = buf_instr_r;
                err_s   = buf_err_r;
                if (!stall_in) begin
                    en_base_s    = 1'b1;
                    pc_base_s    = pc_r + 16'd2;
                    state_base_s = buf_halt_r ? ST_HALTED : ST_FETCH;
                end else begin
                    state_base_s = ST_HOLD;
                end
            end
            ST_SQUASH: begin
                // The stale request cannot be withdrawn; wait it out and drop its data.
                req_s        = 1'b1;
                addr_s       = sq_addr_r;
                state_base_s = bus.imem_done ? ST_FETCH : ST_SQUASH;
            end
            ST_HALTED: begin
                state_base_s = ST_HALTED;
            end
            default: begin
                state_base_s = ST_FETCH;
            end
        endcase

        if (redirect_valid) begin
            ifid_en_s     = 1'b0;
            pc_nxt_s      = redirect_pc;
            state_nxt_s   = (req_s && !bus.imem_done) ? ST_SQUASH : ST_FETCH;
            sq_addr_nxt_s = addr_s;
        end else begin
            ifid_en_s     = en_base_s;
            pc_nxt_s      = pc_base_s;
            state_nxt_s   = state_base_s;
            sq_addr_nxt_s = sq_addr_r;
        end
    end

    // State, PC, squash address and stall buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_FETCH;
            pc_r        <= RESET_PC;
            sq_addr_r   <= RESET_PC;
            buf_instr_r <= NOP_INSTR;
            buf_err_r   <= 1'b0;
            buf_halt_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            sq_addr_r   <= sq_addr_nxt_s;
            buf_instr_r <= buf_instr_nxt_s;
            buf_err_r   <= buf_err_nxt_s;
            buf_halt_r  <= buf_halt_nxt_s;
        end
    end

    // Same-cycle hits require combinational delivery; rst_n gating drops a
    // pending request and any write the instant reset asserts.
    assign bus.imem_rd         = req_s & rst_n;
    assign bus.imem_addr       = addr_s;
    assign bus.ifid_en         = ifid_en_s & rst_n;
    assign bus.instr_out       = rst_n ? instr_s : NOP_INSTR;
    assign bus.err_out         = err_s & rst_n;
    assign bus.pc_current_out  = pc_r;
    assign bus.pc_plus_two_out = pc_r + 16'd2;

endmodule
